// File: rtl/aes_sub_bytes_seq.sv
// rtl/aes_sub_bytes_seq.sv - sequential AES SubBytes stage with valid/yumi output handshake
//
// aes_sbox          : combinational AES S-box ROM, one byte in, one byte out.
// aes_sub_bytes_seq : latches a 128-bit state and substitutes LANES bytes per cycle.
//                     The result is held until the downstream consumer takes it.
//   clk_i   in   1    clock
//   reset_i in   1    synchronous active-high reset
//   data_i  in   128  input state, byte k = data_i[127-8k -: 8], k = r + 4c
//   v_i     in   1    data_i valid
//   ready_o out  1    block can accept a state (IDLE)
//   data_o  out  128  substituted state (ShiftRows-permuted when enabled)
//   v_o     out  1    data_o valid
//   yumi_i  in   1    downstream consumes data_o
// Optional macro: AES_SUB_BYTES_SHIFT_ROWS_EN applies ShiftRows wiring to data_o.

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    // Entry for input x sits in the byte at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [7:0] w_rev_idx;

    // Inverting the byte maps entry x onto the low-first slice position 255-x.
    assign w_rev_idx = ~i_byte;
    assign o_byte    = SBOX_TABLE[{w_rev_idx, 3'b000} +: 8];
endmodule

module aes_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [127:0] data_i,
    input  logic         v_i,
    output logic         ready_o,
    output logic [127:0] data_o,
    output logic         v_o,
    input  logic         yumi_i
);
    localparam int GROUPS = 16 / LANES;
    localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_fsm;
    logic [CW-1:0]   r_cnt;
    logic [127:0]    r_state;
    logic            r_v_o;

    logic [7:0]      w_lane_in  [LANES];
    logic [7:0]      w_lane_out [LANES];
    logic [127:0]    w_state_next;

    // Lane l of group cnt works on byte cnt*LANES + l.
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign w_lane_in[l] = r_state[127 - 8 * (int'(r_cnt) * LANES + l) -: 8];
            aes_sbox u_sbox (
                .i_byte (w_lane_in[l]),
                .o_byte (w_lane_out[l])
            );
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        for (int l = 0; l < LANES; l++) begin
            w_state_next[127 - 8 * (int'(r_cnt) * LANES + l) -: 8] = w_lane_out[l];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_fsm   <= IDLE;
            r_cnt   <= '0;
            r_state <= '0;
            r_v_o   <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (v_i) begin
                        r_state <= data_i;
                        r_cnt   <= '0;
                        r_fsm   <= BUSY;
                    end
                end
                BUSY: begin
                    r_state <= w_state_next;
                    if (r_cnt == CW'(GROUPS - 1)) begin
                        r_cnt <= '0;
                        r_fsm <= DONE;
                        r_v_o <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    // Input valid is deliberately ignored here; only yumi moves us on.
                    if (yumi_i) begin
                        r_fsm <= IDLE;
                        r_v_o <= 1'b0;
                    end
                end
                default: begin
                    r_fsm <= IDLE;
                    r_v_o <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = (r_fsm == IDLE);
    assign v_o     = r_v_o;

`ifdef AES_SUB_BYTES_SHIFT_ROWS_EN
    // Output byte (r,c) is the substituted byte (r,(c+r) mod 4).
    generate
        for (genvar r = 0; r < 4; r++) begin : g_row
            for (genvar c = 0; c < 4; c++) begin : g_col
                assign data_o[127 - 8 * (r + 4 * c) -: 8] =
                    r_state[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
            end
        end
    endgenerate
`else
    assign data_o = r_state;
`endif
endmodule
